// File: rtl/gtech_nibble_feed_fifo_pkg.sv
// Shared constants and width helpers for the nibble feed FIFO and its storage.
package gtech_fifo_pkg;

    localparam int DEF_NIBBLE_W = 4;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_AF_LEVEL = 3;

    // Ceiling log2, usable in constant expressions (clog2(1) == 0).
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Address bits, pointer bits (address plus wrap bit) and occupancy bits.
    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gtech_nibble_feed_fifo_if.sv
// Producer/consumer bundle of the nibble feed FIFO; master is the testbench or
// surrounding logic, slave is the FIFO itself.
interface gtech_nibble_feed_fifo_if
    import gtech_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_NIBBLE_W,
    parameter int DEPTH = DEF_DEPTH
);

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, full, empty, almost_full
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, full, empty, almost_full
    );

endinterface

// File: rtl/gtech_nibble_feed_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port so the FIFO head can fall through in the same cycle.
module gtech_fifo_mem
    import gtech_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_NIBBLE_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [addr_w(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [addr_w(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Contents are deliberately not reset; emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/gtech_nibble_feed_fifo.sv
// Valid/ready elastic buffer feeding the 4-bit register bank: pointers, count,
// flag decode and handshake; storage lives in gtech_fifo_mem.
module gtech_nibble_feed_fifo
    import gtech_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_NIBBLE_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic                    CP,
    input  logic                    CD,
    gtech_nibble_feed_fifo_if.slave bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] mem_rdata;
    logic             empty_w;
    logic             full_w;
    logic             push;
    logic             pop;

    // Same address with differing wrap bits means the write side lapped the read side.
    assign empty_w = (wr_ptr_reg == rd_ptr_reg);
    assign full_w  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // in_ready depends only on registered state, so out_ready never reaches it.
    assign push = bus.in_valid && !full_w;
    assign pop  = bus.out_ready && !empty_w;

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    gtech_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CP),
        .we    (push),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Stale storage is masked so the bank never sees leftover data while empty.
    assign bus.out_data    = empty_w ? '0 : mem_rdata;
    assign bus.out_valid   = !empty_w;
    assign bus.in_ready    = !full_w;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.count       = count_reg;
    assign bus.almost_full = (count_reg >= CW'(AF_LEVEL));

endmodule

// File: tb/tb_gtech_nibble_feed_fifo.sv
// Self-checking bench: table-driven fill/drain, directed corner sequences and a
// random run, all checked against a queue model of the FIFO.
module tb_gtech_nibble_feed_fifo;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic CP;
    logic CD;

    gtech_nibble_feed_fifo_if #(.WIDTH(4), .DEPTH(DEPTH)) bus ();

    gtech_nibble_feed_fifo #(
        .WIDTH    (4),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF)
    ) dut (
        .CP  (CP),
        .CD  (CD),
        .bus (bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct {
        bit       iv;
        bit [3:0] d;
        bit       ordy;
        bit [3:0] head;   // out_data expected just before the edge
        int       cnt;    // state expected just after the edge
        bit       full;
        bit       empty;
        bit       af;
    } vec_t;

    vec_t     tbl [10];
    logic [3:0] sb [$];
    int       total;
    int       bad;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input logic [3:0] d, input bit ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    task automatic model_check();
        int n;
        n = sb.size();
        chk("count",       int'(bus.count),       n);
        chk("full",        int'(bus.full),        int'(n == DEPTH));
        chk("empty",       int'(bus.empty),       int'(n == 0));
        chk("almost_full", int'(bus.almost_full), int'(n >= AF));
        chk("in_ready",    int'(bus.in_ready),    int'(n < DEPTH));
        chk("out_valid",   int'(bus.out_valid),   int'(n > 0));
        chk("out_data",    int'(bus.out_data),    (n > 0) ? int'(sb[0]) : 0);
    endtask

    // Check pre-edge outputs against the model, then apply the handshake to it.
    task automatic pre_edge();
        logic [3:0] exp;
        bit         do_push;
        bit         do_pop;
        @(negedge CP);
        model_check();
        do_pop  = bus.out_ready && (sb.size() > 0);
        do_push = bus.in_valid && (sb.size() < DEPTH);
        if (do_pop) begin
            exp = sb.pop_front();
            chk("pop_data", int'(bus.out_data), int'(exp));
            $display("pop  data=%h expected=%h", bus.out_data, exp);
        end
        if (do_push) begin
            sb.push_back(bus.in_data);
            $display("push data=%h", bus.in_data);
        end
    endtask

    task automatic post_edge();
        @(posedge CP);
        #1;
    endtask

    task automatic step(input bit iv, input logic [3:0] d, input bit ordy);
        drive(iv, d, ordy);
        pre_edge();
        post_edge();
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
            step(1'b0, 4'h0, 1'b1);
        end
        chk("drained_empty", int'(bus.empty), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"},     int'(bus.empty),       1);
        chk({tag, "_full"},      int'(bus.full),        0);
        chk({tag, "_count"},     int'(bus.count),       0);
        chk({tag, "_out_valid"}, int'(bus.out_valid),   0);
        chk({tag, "_in_ready"},  int'(bus.in_ready),    1);
        chk({tag, "_af"},        int'(bus.almost_full), 0);
        chk({tag, "_out_data"},  int'(bus.out_data),    0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 4'h0, 1'b0);

        tbl[0] = '{1'b1, 4'hA, 1'b0, 4'h0, 1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'h5, 1'b0, 4'hA, 2, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'hC, 1'b0, 4'hA, 3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 4'h3, 1'b0, 4'hA, 4, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 4'hF, 1'b0, 4'hA, 4, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 4'h0, 1'b1, 4'hA, 3, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 4'h0, 1'b1, 4'h5, 2, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 4'h0, 1'b1, 4'hC, 1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 4'h0, 1'b1, 4'h3, 0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 4'h0, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0};

        // Power-on reset, released away from the active edge.
        CD = 1'b1;
        #1 CD = 1'b0;
        #1 chk_reset_outputs("por");
        #1 CD = 1'b1;
        post_edge();

        // Fill to full, refuse a fifth word, then drain in order.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            pre_edge();
            chk($sformatf("tbl%0d_head", i), int'(bus.out_data), int'(tbl[i].head));
            post_edge();
            chk($sformatf("tbl%0d_count", i), int'(bus.count), tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i), int'(bus.full), int'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), int'(bus.empty), int'(tbl[i].empty));
            chk($sformatf("tbl%0d_af", i), int'(bus.almost_full), int'(tbl[i].af));
            chk($sformatf("tbl%0d_in_ready", i), int'(bus.in_ready), int'(!tbl[i].full));
        end

        // Full with push and pop together: only the pop happens, push lands next cycle.
        step(1'b1, 4'hA, 1'b0);
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        chk("fs_full", int'(bus.full), 1);
        step(1'b1, 4'h7, 1'b1);
        chk("fs_pop_only_count", int'(bus.count), 3);
        chk("fs_in_ready_back", int'(bus.in_ready), 1);
        step(1'b1, 4'h7, 1'b1);
        chk("fs_push_pop_count", int'(bus.count), 3);
        drain();

        // Reset mid-burst with three words stored; clear must act before the next edge.
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        #2 CD = 1'b0;
        #1 chk_reset_outputs("mid");
        sb.delete();
        #2 CD = 1'b1;
        post_edge();
        step(1'b1, 4'h9, 1'b0);
        chk("post_reset_head", int'(bus.out_data), 9);
        step(1'b0, 4'h0, 1'b1);

        // Streaming one word per cycle over three full pointer laps.
        step(1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i + 1), 1'b1);
            chk($sformatf("stream%0d_count", i), int'(bus.count), 1);
        end
        drain();

        // Random traffic: producer-heavy half, then consumer-heavy half.
        for (int i = 0; i < 2000; i++) begin
            if (i < 1000) begin
                step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) == 1));
            end else begin
                step(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) != 0));
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
